// File: rtl/convpress_pkg.sv
// ----------------------------------------------------------------------------
// convpress_pkg
//   Shared definitions for the convpress node: brick geometry, the decoder
//   FSM state type and lane-slice helpers shared by the N3 compressor and
//   decoder.
//   No ports (package).
// ----------------------------------------------------------------------------
package convpress_pkg;

   // Brick geometry
   localparam int N         = 16;          // bits per neuron value
   localparam int TN        = 16;          // lanes per brick / per compressed word
   localparam int OFFSET_SZ = 4;           // bits per idx field
   localparam int ADDR_SZ   = 6;           // NBin address width
   localparam int CNT_SZ    = 5;           // width of valid-pair count
   localparam int NNZ_SZ    = CNT_SZ + 1;  // width of the emitted nnz field

   localparam logic [ADDR_SZ-1:0] ADDR_MAX = {ADDR_SZ{1'b1}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Value of lane k from a packed Tn*N word
   function automatic logic [N-1:0] lane_value(input logic [TN*N-1:0] data, input int k);
      return data[k*N +: N];
   endfunction

   // Index field of lane k from a packed Tn*OFFSET_SZ word
   function automatic logic [OFFSET_SZ-1:0] lane_idx(input logic [TN*OFFSET_SZ-1:0] idx, input int k);
      return idx[k*OFFSET_SZ +: OFFSET_SZ];
   endfunction

   // Pair count limited to the number of lanes in a word
   function automatic logic [CNT_SZ-1:0] clamp_count(input logic [CNT_SZ-1:0] count);
      return (count > CNT_SZ'(TN)) ? CNT_SZ'(TN) : count;
   endfunction

   // Running non-zero count, saturating at Tn
   function automatic logic [NNZ_SZ-1:0] sat_add_nnz(input logic [NNZ_SZ-1:0] acc,
                                                     input logic [CNT_SZ-1:0] add);
      logic [NNZ_SZ-1:0] sum;
      sum = acc + NNZ_SZ'(add);
      return (sum > NNZ_SZ'(TN)) ? NNZ_SZ'(TN) : sum;
   endfunction

endpackage

// File: rtl/convpress_scatter_lane.sv
// ----------------------------------------------------------------------------
// convpress_scatter_lane
//   Selects, for one dense lane LANE, the value of the highest-numbered valid
//   compressed lane whose idx field points at LANE.
//   Ports:
//     i_data   in  Tn*N          packed compressed values
//     i_idx    in  Tn*OFFSET_SZ  packed destination indices
//     i_count  in  CNT_SZ        number of valid pairs (already clamped to Tn)
//     o_hit    out 1             some valid pair targets this lane
//     o_value  out N             value of the winning pair (0 when no hit)
// ----------------------------------------------------------------------------
module convpress_scatter_lane
   import convpress_pkg::*;
#(
   parameter int LANE = 0
) (
   input  logic [TN*N-1:0]         i_data,
   input  logic [TN*OFFSET_SZ-1:0] i_idx,
   input  logic [CNT_SZ-1:0]       i_count,
   output logic                    o_hit,
   output logic [N-1:0]            o_value
);

   localparam logic [OFFSET_SZ-1:0] LANE_ID = OFFSET_SZ'(LANE);

   // Priority select: scanning upward lets the highest matching lane win
   always_comb begin
      o_hit   = 1'b0;
      o_value = {N{1'b0}};
      for (int k = 0; k < TN; k++) begin
         logic match_s;
         match_s = (CNT_SZ'(k) < i_count) && (lane_idx(i_idx, k) == LANE_ID);
         o_hit   = o_hit | match_s;
         o_value = match_s ? lane_value(i_data, k) : o_value;
      end
   end

endmodule

// File: rtl/convpress_n3_decoder.sv
// ----------------------------------------------------------------------------
// convpress_n3_decoder
//   Receive side of the N3 compressor stream. Compressed words of (value, idx)
//   pairs are scattered into a dense Tn-lane accumulator; the word flagged
//   last closes the brick, which is then written to NBin at an
//   auto-incrementing address.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     i_start         load pointer with i_base_addr, discard any partial brick
//     i_base_addr     first NBin address of the layer
//     i_valid/o_ready compressed-word handshake
//     i_data/i_idx    packed values / destination lane per value
//     i_count         number of valid pairs (lanes 0..count-1)
//     i_last          word closes the current brick
//     i_out_ready     NBin write port free this cycle
//     o_nbin_data     dense brick
//     o_nbin_addr     NBin write address
//     o_nbin_wen      NBin write strobe
//     o_brick_nnz     pairs accumulated into the emitted brick (saturates at Tn)
//     o_wrap          one-cycle pulse after the pointer wraps to 0
// ----------------------------------------------------------------------------
module convpress_n3_decoder
   import convpress_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   input  logic [ADDR_SZ-1:0]      i_base_addr,
   input  logic                    i_valid,
   output logic                    o_ready,
   input  logic [TN*N-1:0]         i_data,
   input  logic [TN*OFFSET_SZ-1:0] i_idx,
   input  logic [CNT_SZ-1:0]       i_count,
   input  logic                    i_last,
   input  logic                    i_out_ready,
   output logic [TN*N-1:0]         o_nbin_data,
   output logic [ADDR_SZ-1:0]      o_nbin_addr,
   output logic                    o_nbin_wen,
   output logic [NNZ_SZ-1:0]       o_brick_nnz,
   output logic                    o_wrap
);

   // State and datapath registers
   state_t              state_q,    state_d;
   logic [ADDR_SZ-1:0]  ptr_q,      ptr_d;
   logic [TN*N-1:0]     accum_q,    accum_d;
   logic [NNZ_SZ-1:0]   nnz_q,      nnz_d;
   logic [TN*N-1:0]     out_data_q, out_data_d;
   logic [NNZ_SZ-1:0]   out_nnz_q,  out_nnz_d;
   logic                wrap_q,     wrap_d;

   // Combinational helpers
   logic [CNT_SZ-1:0]   eff_count_s;
   logic [TN-1:0]       hit_s;
   logic [TN*N-1:0]     scat_val_s;
   logic [TN*N-1:0]     merged_s;
   logic [NNZ_SZ-1:0]   nnz_sum_s;
   logic                ready_s;
   logic                wen_s;
   logic                accept_s;

   assign eff_count_s = clamp_count(i_count);
   assign nnz_sum_s   = sat_add_nnz(nnz_q, eff_count_s);

   // One priority selector per dense lane
   for (genvar j = 0; j < TN; j++) begin : g_lane
      convpress_scatter_lane #(
         .LANE (j)
      ) u_lane (
         .i_data  (i_data),
         .i_idx   (i_idx),
         .i_count (eff_count_s),
         .o_hit   (hit_s[j]),
         .o_value (scat_val_s[j*N +: N])
      );
   end

   // Overlay this word's pairs on the accumulator; untouched lanes keep older values
   always_comb begin
      merged_s = accum_q;
      for (int j = 0; j < TN; j++) begin
         merged_s[j*N +: N] = hit_s[j] ? scat_val_s[j*N +: N] : accum_q[j*N +: N];
      end
   end

   // Input readiness by state; HOLD may refill in the same cycle it drains
   always_comb begin
      ready_s = 1'b0;
      case (state_q)
         IDLE:    ready_s = 1'b0;
         ACCUM:   ready_s = 1'b1;
         HOLD:    ready_s = i_out_ready;
         default: ready_s = 1'b0;
      endcase
   end

   // i_start (and reset) take precedence: no word accepted, no pending write issued
   assign o_ready  = ready_s & ~i_start & ~rst;
   assign wen_s    = (state_q == HOLD) & i_out_ready & ~i_start & ~rst;
   assign accept_s = i_valid & o_ready;

   // Next-state logic for FSM, pointer, accumulator and output registers
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      accum_d    = accum_q;
      nnz_d      = nnz_q;
      out_data_d = out_data_q;
      out_nnz_d  = out_nnz_q;
      wrap_d     = 1'b0;
      if (i_start) begin
         state_d = ACCUM;
         ptr_d   = i_base_addr;
         accum_d = {(TN*N){1'b0}};
         nnz_d   = {NNZ_SZ{1'b0}};
      end else begin
         // Completing a write advances the pointer; wrap is flagged for the next cycle
         if (wen_s) begin
            state_d = ACCUM;
            ptr_d   = ptr_q + ADDR_SZ'(1);
            wrap_d  = (ptr_q == ADDR_MAX);
         end else begin
            state_d = state_q;
         end
         // A new word may land in the same cycle; a closing word overrides to HOLD
         if (accept_s) begin
            if (i_last) begin
               out_data_d = merged_s;
               out_nnz_d  = nnz_sum_s;
               accum_d    = {(TN*N){1'b0}};
               nnz_d      = {NNZ_SZ{1'b0}};
               state_d    = HOLD;
            end else begin
               accum_d    = merged_s;
               nnz_d      = nnz_sum_s;
               state_d    = ACCUM;
            end
         end else begin
            accum_d = accum_q;
         end
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= {ADDR_SZ{1'b0}};
         accum_q    <= {(TN*N){1'b0}};
         nnz_q      <= {NNZ_SZ{1'b0}};
         out_data_q <= {(TN*N){1'b0}};
         out_nnz_q  <= {NNZ_SZ{1'b0}};
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         accum_q    <= accum_d;
         nnz_q      <= nnz_d;
         out_data_q <= out_data_d;
         out_nnz_q  <= out_nnz_d;
         wrap_q     <= wrap_d;
      end
   end

   assign o_nbin_data = out_data_q;
   assign o_nbin_addr = ptr_q;
   assign o_nbin_wen  = wen_s;
   assign o_brick_nnz = out_nnz_q;
   assign o_wrap      = wrap_q;

endmodule
